nios_pio_edge_capture_in: RTL
=============================

# nios_pio_edge_capture_in

Avalon-MM slave input port with edge capture and interrupt for the Nios II system: the read-side counterpart of the LED output PIO. It samples an external parallel input (push-buttons, switches), synchronizes it into the system clock domain, latches selected edges per bit, and raises a level interrupt to the CPU. Software reads the pin state, masks interrupts, and clears captured edges through a four-word register map.

## Interface
- WIDTH, 4: number of input bits, 1..32.
- EDGE_TYPE, 1: edge captured per bit: 0 = rising, 1 = falling, 2 = any.
- SYNC_RESET, all ones: reset value of the synchronizer and previous-value registers. All ones suits active-low keys.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  2  word address of the register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits [WIDTH-1:0] are used
- in_port  in  WIDTH  external asynchronous inputs
- readdata  out  32  registered read data; bits [31:WIDTH] are always 0
- irq  out  1  level interrupt to the CPU

## Operation
- **Register map**
  - 0 DATA (RO): synchronized pin state.
  - 1 reserved: reads 0; writes are ignored.
  - 2 IRQMASK (RW): per-bit interrupt enable.
  - 3 EDGECAPTURE (RW1C): per-bit captured edges.
- **Write qualification:** a write occurs when chipselect=1 and write_n=0. Writes to addresses 0 and 1 have no effect.
- **Synchronizer:** in_port passes through two flops, s1 then s2. s2 is the DATA value.
- **Previous-value register:** p <= s2 every cycle.
- **Edge detect (combinational):**
  - rise = s2 & ~p
  - fall = ~s2 & p
  - edge = rise, fall, or rise|fall, selected by EDGE_TYPE.
- **EDGECAPTURE update, per bit i:**
  - Set when edge[i]=1.
  - Cleared by a write to address 3 with writedata[i]=1.
  - A bit written 0 is unchanged.
  - If set and clear occur in the same cycle, set wins, so no edge is lost.
- **IRQMASK:** written with writedata[WIDTH-1:0] on a write to address 2.
- **Interrupt:** irq <= |(EDGECAPTURE & IRQMASK), registered.
- **Read path:** readdata <= {zeros, mux(address)} every cycle, independent of chipselect. The mux selects DATA, 0, IRQMASK or EDGECAPTURE.

## Timing
- **Reset values:**
  - s1, s2 and p = SYNC_RESET.
  - IRQMASK = 0, EDGECAPTURE = 0.
  - readdata = 0, irq = 0.
  - Because p equals s2 at reset, releasing reset produces no spurious edge.
- **Input path:** an in_port change sampled at rising edge k reaches s1 at k and s2 at k+1. After that:
  - EDGECAPTURE bit set at edge k+2.
  - readdata(DATA) valid after k+2.
  - irq asserted after edge k+3 if the bit is masked in.
- **Pulse width:** input pulses shorter than one clock period may be missed. Pulses of two or more cycles are always captured.
- **Read latency:** fixed at 1 cycle. readdata reflects the address presented in the previous cycle.
- **Read-after-write:** a read issued in the cycle after a write sees the new IRQMASK/EDGECAPTURE value.
- **Interrupt clear:** an EDGECAPTURE clear at edge t drops irq at edge t+1, unless another masked edge is set at t.
- **Mask change:** changing IRQMASK affects irq one cycle later. Masked-off bits keep capturing edges; unmasking a bit with a pending capture raises irq.
- **Reset mid-operation:** reset asynchronously forces every register to its reset value and drops irq immediately. Pending edges are discarded.

## Test plan
- **Reset:** assert reset mid-traffic with in_port=0xF.
  - irq=0 and readdata=0 immediately.
  - After release, read address 0 returns 0x0000000F and address 3 returns 0.
- **Falling edge to irq (EDGE_TYPE=1):** write IRQMASK=0x1, then drive in_port[0] 1->0 at edge k.
  - EDGECAPTURE=0x1 after k+2; irq=1 after k+3.
  - Write 0x1 to address 3: irq=0 one cycle later; EDGECAPTURE reads 0.
- **Mask off, then unmask:** IRQMASK=0, drive in_port[2] 1->0.
  - EDGECAPTURE=0x4 and irq stays 0.
  - Write IRQMASK=0x4: irq=1 one cycle later.
- **Simultaneous set and clear:** write 0x2 to address 3 in the same cycle bit 1 detects a new edge.
  - Bit 1 remains 1 and irq stays high.
  - Partial clear: with EDGECAPTURE=0x3, write 0x1; EDGECAPTURE reads 0x2.
- **Edge-type sweep and reserved/DATA behaviour:**
  - EDGE_TYPE=0 captures only 0->1; EDGE_TYPE=2 captures both transitions of a 0->1->0 pulse of 3 cycles.
  - A 1-cycle glitch is captured or missed; both outcomes are legal.
  - Address 1 always reads 0; writing 0xFFFFFFFF to addresses 0 and 1 changes nothing.
  - With WIDTH=4, readdata[31:4] is always 0.

Source files
------------

// File: rtl/nios_pio_edge_capture_in.sv
// nios_pio_edge_capture_in
// Avalon-MM input PIO with per-bit edge capture and a level interrupt.
// External pins are double-flopped into the clk domain. Selected edges are
// latched in EDGECAPTURE, which software clears by writing ones to the bits.
// The interrupt is the OR of captured edges that IRQMASK enables.
//
// Register map (word addresses):
//   0  DATA         RO    synchronized pin state
//   1  reserved     RO    reads 0, writes ignored
//   2  IRQMASK      RW    per-bit interrupt enable
//   3  EDGECAPTURE  RW1C  per-bit captured edges

module nios_pio_edge_capture_in #(
    parameter int unsigned      WIDTH      = 4,            // 1..32 input bits
    parameter int unsigned      EDGE_TYPE  = 1,            // 0 rising, 1 falling, 2 any
    parameter logic [WIDTH-1:0] SYNC_RESET = {WIDTH{1'b1}} // idle level of the pins
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic [1:0] {
        ADDR_DATA     = 2'd0,
        ADDR_RESERVED = 2'd1,
        ADDR_IRQMASK  = 2'd2,
        ADDR_EDGECAP  = 2'd3
    } reg_addr_e;

    // Synchronizer stages and the previous-value register used for edge detect.
    logic [WIDTH-1:0] sync_s1;
    logic [WIDTH-1:0] sync_s2;
    logic [WIDTH-1:0] prev_q;

    // Software-visible state.
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;

    // Combinational helpers.
    logic             wr_en;
    logic             mask_we;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] rise_det;
    logic [WIDTH-1:0] fall_det;
    logic [WIDTH-1:0] edge_det;
    logic [31:0]      rd_next;

    // Only writedata[WIDTH-1:0] carries register bits; fold the rest into a
    // named sink so the unused upper bits are explicit.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    // Avalon write qualification and per-register write strobes.
    assign wr_en    = chipselect & ~write_n;
    assign mask_we  = wr_en && (reg_addr_e'(address) == ADDR_IRQMASK);
    assign edge_clr = (wr_en && (reg_addr_e'(address) == ADDR_EDGECAP))
                    ? writedata[WIDTH-1:0] : '0;

    // Raw transitions between the synchronized value and its previous sample.
    assign rise_det =  sync_s2 & ~prev_q;
    assign fall_det = ~sync_s2 &  prev_q;

    // Pick the transitions this instance captures.
    // NOTE: every always_comb output gets a value on every path (here via the
    // default branch); a missing assignment would infer a latch.
    always_comb begin
        case (EDGE_TYPE)
            0:       edge_det = rise_det;
            1:       edge_det = fall_det;
            default: edge_det = rise_det | fall_det;
        endcase
    end

    // Two-flop synchronizer plus previous-value register. All three share the
    // same reset value, so releasing reset can never look like an edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; blocking here would collapse
    // the synchronizer chain into a single stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_s1 <= SYNC_RESET;
            sync_s2 <= SYNC_RESET;
            prev_q  <= SYNC_RESET;
        end else begin
            sync_s1 <= in_port;
            sync_s2 <= sync_s1;
            prev_q  <= sync_s2;
        end
    end

    // Interrupt mask register, written from the low WIDTH bits of writedata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
        end else if (mask_we) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // Edge capture: write-one-to-clear, with a new edge overriding a clear in
    // the same cycle so software can never lose an edge it has not seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clr) | edge_det;
        end
    end

    // Registered level interrupt from enabled captured edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_capture & irq_mask);
        end
    end

    // Read mux, zero-extended to the 32-bit bus; independent of chipselect.
    always_comb begin
        rd_next = '0;
        case (reg_addr_e'(address))
            ADDR_DATA:     rd_next[WIDTH-1:0] = sync_s2;
            ADDR_RESERVED: rd_next            = '0;
            ADDR_IRQMASK:  rd_next[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP:  rd_next[WIDTH-1:0] = edge_capture;
            default:       rd_next            = '0;
        endcase
    end

    // One-cycle registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule
